// File: rtl/sprite_line_buffer.sv
// sprite_line_buffer: ping-pong scanline buffer between the sprite engine and
// video scan-out. One bank is read (and cleared) at the pixel rate while the
// sprite engine fills the other. The banks swap on every rising edge of hbl.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_CLEAR | zero both banks one address per clk; writes, reads and swaps are ignored
// S_RUN   | normal operation: swaps, sprite writes and clear-on-read scan-out
module sprite_line_buffer #(
  parameter int DW     = 12,
  parameter int VTOTAL = 288
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_pix,
  input  logic [8:0]    hc,
  input  logic [8:0]    vc,
  input  logic          hbl,
  input  logic          vbl,
  input  logic          wr_en,
  input  logic [8:0]    wr_x,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_done,
  output logic          line_start,
  output logic [8:0]    wr_line,
  output logic [DW-1:0] pix_out,
  output logic          pix_valid,
  output logic          overrun,
  output logic          ready
);

  localparam logic S_CLEAR = 1'b0;
  localparam logic S_RUN   = 1'b1;

  logic          state;
  logic [7:0]    addr;
  logic          sel;
  logic          pending;
  logic          hbl_d;

  logic [DW-1:0] bank0 [0:255];
  logic [DW-1:0] bank1 [0:255];

  logic          run;
  logic          swap;
  logic          rd;
  logic          wr_ok;
  logic [8:0]    next_line;
  logic [DW-1:0] rd_word;

  logic          we0, we1;
  logic [7:0]    a0, a1;
  logic [DW-1:0] d0, d1;

  assign run       = (state == S_RUN);
  assign ready     = run;
  assign swap      = run & hbl & ~hbl_d;
  assign rd        = run & clk_pix & ~hbl & ~vbl;
  assign wr_ok     = run & wr_en & ~wr_x[8] & (wr_data[3:0] != 4'd0);
  assign next_line = (vc == 9'(VTOTAL)) ? 9'd0 : vc + 9'd1;
  assign rd_word   = sel ? bank1[hc[7:0]] : bank0[hc[7:0]];

  // Bank 0 port select: clear sweep, sprite write (when it is the write bank,
  // sel=1) or clear-on-read (when it is the read bank, sel=0). Uses the sel
  // value before any toggle this cycle, so a write coincident with a swap
  // lands in the bank that was being filled.
  always_comb begin
    we0 = 1'b0;
    a0  = addr;
    d0  = '0;
    if (!run) begin
      we0 = 1'b1;
    end else if (sel) begin
      if (wr_ok) begin
        we0 = 1'b1;
        a0  = wr_x[7:0];
        d0  = wr_data;
      end
    end else if (rd) begin
      we0 = 1'b1;
      a0  = hc[7:0];
    end
  end

  // Bank 1 port select: mirror of bank 0 with the roles of sel swapped.
  always_comb begin
    we1 = 1'b0;
    a1  = addr;
    d1  = '0;
    if (!run) begin
      we1 = 1'b1;
    end else if (!sel) begin
      if (wr_ok) begin
        we1 = 1'b1;
        a1  = wr_x[7:0];
        d1  = wr_data;
      end
    end else if (rd) begin
      we1 = 1'b1;
      a1  = hc[7:0];
    end
  end

  // Bank 0 storage; contents are zeroed by the CLEAR sweep rather than reset.
  always_ff @(posedge clk) begin
    if (we0) bank0[a0] <= d0;
  end

  // Bank 1 storage.
  always_ff @(posedge clk) begin
    if (we1) bank1[a1] <= d1;
  end

  // Sequencer: sweep all 256 addresses after reset, then stay in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_CLEAR;
      addr  <= 8'd0;
    end else begin
      case (state)
        S_CLEAR: begin
          addr <= addr + 8'd1;
          if (addr == 8'hFF) state <= S_RUN;
        end
        default: state <= S_RUN;
      endcase
    end
  end

  // Line swap bookkeeping: bank select, render handshake and overrun detect.
  // A swap outranks a coincident wr_done so the new line is left pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      hbl_d      <= 1'b0;
      sel        <= 1'b0;
      pending    <= 1'b0;
      line_start <= 1'b0;
      overrun    <= 1'b0;
      wr_line    <= 9'd0;
    end else begin
      hbl_d      <= hbl;
      line_start <= swap;
      overrun    <= swap & pending;
      if (swap) begin
        sel     <= ~sel;
        wr_line <= next_line;
        pending <= 1'b1;
      end else if (wr_done) begin
        pending <= 1'b0;
      end
    end
  end

  // Scan-out register: one-clk read latency, zero when no read occurs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_out   <= '0;
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= rd;
      pix_out   <= rd ? rd_word : '0;
    end
  end

endmodule

// File: tb/tb_sprite_line_buffer.sv
// Directed bench for sprite_line_buffer: clear sweep, swap handshake,
// write/readback, clear-on-read, transparency, overrun and line wrap.
module tb_sprite_line_buffer;

  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_pix;
  logic [8:0]    hc, vc;
  logic          hbl, vbl;
  logic          wr_en;
  logic [8:0]    wr_x;
  logic [DW-1:0] wr_data;
  logic          wr_done;
  logic          line_start;
  logic [8:0]    wr_line;
  logic [DW-1:0] pix_out;
  logic          pix_valid;
  logic          overrun;
  logic          ready;

  int checks = 0;
  int errors = 0;

  sprite_line_buffer #(.DW(DW), .VTOTAL(288)) dut (
    .clk(clk), .reset(reset), .clk_pix(clk_pix), .hc(hc), .vc(vc),
    .hbl(hbl), .vbl(vbl), .wr_en(wr_en), .wr_x(wr_x), .wr_data(wr_data),
    .wr_done(wr_done), .line_start(line_start), .wr_line(wr_line),
    .pix_out(pix_out), .pix_valid(pix_valid), .overrun(overrun), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Rising hbl with given vc; optional coincident wr_done.
  task automatic do_swap(input logic [8:0] v, input logic wd,
                         input logic exp_ovr, input logic [8:0] exp_line);
    vc = v; hbl = 1'b1; wr_done = wd;
    tick();
    wr_done = 1'b0;
    chk("swap_line_start", 32'(line_start), 32'd1);
    chk("swap_wr_line", 32'(wr_line), 32'(exp_line));
    chk("swap_overrun", 32'(overrun), 32'(exp_ovr));
    tick();
    chk("line_start_pulse", 32'(line_start), 32'd0);
    chk("overrun_pulse", 32'(overrun), 32'd0);
    hbl = 1'b0;
    tick();
  endtask

  task automatic read_px(input logic [8:0] col, input logic [DW-1:0] exp);
    hc = col; clk_pix = 1'b1;
    tick();
    clk_pix = 1'b0;
    chk("pix_valid_hi", 32'(pix_valid), 32'd1);
    chk("pix_out", 32'(pix_out), 32'(exp));
    tick();
    chk("pix_valid_lo", 32'(pix_valid), 32'd0);
  endtask

  task automatic write_px(input logic [8:0] x, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_x = x; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic done();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clk_pix = 1'b0; hc = '0; vc = '0; hbl = 1'b0; vbl = 1'b0;
    wr_en = 1'b0; wr_x = '0; wr_data = '0; wr_done = 1'b0;

    for (int i = 0; i < 5; i++) tick();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_line_start", 32'(line_start), 32'd0);
    chk("rst_wr_line", 32'(wr_line), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_pix_out", 32'(pix_out), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);

    // CLEAR sweep: ready low for 255 edges, hbl activity produces no swap.
    reset = 1'b0;
    for (int i = 1; i <= 255; i++) begin
      if (i == 100) hbl = 1'b1;
      if (i == 110) hbl = 1'b0;
      tick();
      chk("clear_ready", 32'(ready), 32'd0);
      chk("clear_line_start", 32'(line_start), 32'd0);
    end
    tick();
    chk("ready_rise", 32'(ready), 32'd1);

    // Both banks cleared.
    read_px(9'd5, 12'h000);
    do_swap(9'd0, 1'b0, 1'b0, 9'd1);
    read_px(9'd5, 12'h000);
    read_px(9'd200, 12'h000);
    done();

    // Basic line with clear-on-read.
    do_swap(9'd100, 1'b0, 1'b0, 9'd101);
    write_px(9'd10, 12'h123);
    done();
    do_swap(9'd101, 1'b0, 1'b0, 9'd102);
    read_px(9'd9, 12'h000);
    read_px(9'd10, 12'h123);
    read_px(9'd11, 12'h000);
    read_px(9'd10, 12'h000);
    done();

    // Two more swaps without writes.
    do_swap(9'd102, 1'b0, 1'b0, 9'd103);
    done();
    do_swap(9'd103, 1'b0, 1'b0, 9'd104);
    read_px(9'd10, 12'h000);

    // Transparency, out-of-range and overwrite.
    write_px(9'd20, 12'h120);
    write_px(9'd300, 12'h555);
    write_px(9'd30, 12'h111);
    write_px(9'd30, 12'h222);
    done();
    do_swap(9'd104, 1'b0, 1'b0, 9'd105);
    read_px(9'd20, 12'h000);
    read_px(9'd44, 12'h000);
    read_px(9'd30, 12'h222);
    done();

    // Write coincident with swap lands in the pre-toggle write bank.
    wr_en = 1'b1; wr_x = 9'd50; wr_data = 12'h345; vc = 9'd105; hbl = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("ws_line_start", 32'(line_start), 32'd1);
    chk("ws_wr_line", 32'(wr_line), 32'd106);
    chk("ws_overrun", 32'(overrun), 32'd0);
    tick();
    hbl = 1'b0;
    tick();

    // No read during vbl, so column 50 survives.
    vbl = 1'b1; hc = 9'd50; clk_pix = 1'b1;
    tick();
    clk_pix = 1'b0; vbl = 1'b0;
    chk("vbl_pix_valid", 32'(pix_valid), 32'd0);
    chk("vbl_pix_out", 32'(pix_out), 32'd0);
    read_px(9'd50, 12'h345);

    // Overrun: no wr_done since last swap; swap must still happen.
    write_px(9'd60, 12'h456);
    do_swap(9'd106, 1'b0, 1'b1, 9'd107);
    read_px(9'd60, 12'h456);

    // wr_done coincident with swap: no overrun, pending stays set.
    done();
    do_swap(9'd107, 1'b1, 1'b0, 9'd108);
    do_swap(9'd108, 1'b0, 1'b1, 9'd109);

    // Line wrap at VTOTAL.
    do_swap(9'd288, 1'b0, 1'b1, 9'd0);

    // Reset mid-scan.
    hc = 9'd70; clk_pix = 1'b1; reset = 1'b1;
    tick();
    chk("mid_rst_ready", 32'(ready), 32'd0);
    chk("mid_rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("mid_rst_pix_out", 32'(pix_out), 32'd0);
    chk("mid_rst_wr_line", 32'(wr_line), 32'd0);
    chk("mid_rst_line_start", 32'(line_start), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0; clk_pix = 1'b0;
    for (int i = 1; i <= 255; i++) tick();
    chk("reclear_ready_lo", 32'(ready), 32'd0);
    tick();
    chk("reclear_ready_hi", 32'(ready), 32'd1);
    read_px(9'd60, 12'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
